// File: rtl/riscv_br_pkg.sv
// Shared definitions for the branch resolution path: RV32I branch funct3
// encodings and the branch controller state type.
package riscv_br_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_EVAL     = 2'd2,
        ST_REDIRECT = 2'd3
    } br_state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage branch request and pipeline-response bundle for branch_ctrl.
interface branch_ctrl_if #(
    parameter int XLEN = 32
);

    logic            br_valid;
    logic [2:0]      br_funct3;
    logic            opnd_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;

    logic            stall;
    logic            flush;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            br_done;
    logic            br_taken;
    logic            br_illegal;
    logic            br_misalign;

    modport master (
        output br_valid, br_funct3, opnd_ready, rs1_data, rs2_data, pc, imm,
        input  stall, flush, pc_sel, pc_target, br_done, br_taken,
               br_illegal, br_misalign
    );

    modport slave (
        input  br_valid, br_funct3, opnd_ready, rs1_data, rs2_data, pc, imm,
        output stall, flush, pc_sel, pc_target, br_done, br_taken,
               br_illegal, br_misalign
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational RV32I branch condition evaluator: (funct3, a, b) -> {cond, illegal}.
module branch_cond
    import riscv_br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond,
    output logic            illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     cond = (a == b);
            BNE:     cond = (a != b);
            BLT:     cond = ($signed(a) <  $signed(b));
            BGE:     cond = ($signed(a) >= $signed(b));
            BLTU:    cond = (a <  b);
            BGEU:    cond = (a >= b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures one branch from ID, resolves it,
// then drives stall / PC redirect / multi-cycle IF-ID flush.
module branch_ctrl
    import riscv_br_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_ctrl_if.slave     bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int              RC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(FLUSH_CYCLES - 1);

    br_state_e       state;
    br_state_e       state_nxt;
    logic [RC_W-1:0] rcnt;
    logic            capture;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;

    logic            cond;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic            redirect;

    branch_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .funct3  (f3_q),
        .a       (rs1_q),
        .b       (rs2_q),
        .cond    (cond),
        .illegal (illegal)
    );

    // Wrapping add: the carry out of the PC is intentionally dropped.
    assign target   = pc_q + imm_q;
    assign redirect = cond && (target[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    if (bus.opnd_ready) begin
                        capture   = 1'b1;
                        state_nxt = ST_EVAL;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.opnd_ready) begin
                    capture   = 1'b1;
                    state_nxt = ST_EVAL;
                end
            end
            ST_EVAL:     state_nxt = redirect ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: if (rcnt == RC_LAST) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign bus.stall  = (state != ST_IDLE) || bus.br_valid;
    assign bus.flush  = (state == ST_REDIRECT);
    assign bus.pc_sel = (state == ST_REDIRECT) && (rcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= (state == ST_REDIRECT) ? rcnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            pc_q  <= '0;
            imm_q <= '0;
        end else if (capture) begin
            f3_q  <= bus.br_funct3;
            rs1_q <= bus.rs1_data;
            rs2_q <= bus.rs2_data;
            pc_q  <= bus.pc;
            imm_q <= bus.imm;
        end
    end

    // Result flags are one-cycle pulses launched from EVAL; pc_target holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.br_done     <= 1'b0;
            bus.br_taken    <= 1'b0;
            bus.br_illegal  <= 1'b0;
            bus.br_misalign <= 1'b0;
            bus.pc_target   <= '0;
        end else begin
            bus.br_done     <= (state == ST_EVAL);
            bus.br_taken    <= (state == ST_EVAL) && cond;
            bus.br_illegal  <= (state == ST_EVAL) && illegal;
            bus.br_misalign <= (state == ST_EVAL) && cond && !redirect;
            if (state == ST_EVAL) begin
                bus.pc_target <= target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            taken_cnt <= '0;
        end else if ((state == ST_EVAL) && redirect) begin
            taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution controller for the pipelined RISC-V core, sitting between the decode stage and the PC-select mux. It accepts one conditional branch at a time from ID and registers its operands. It evaluates all six RV32I branch conditions through a condition sub-module and computes PC+imm in parallel. It then sequences the pipeline response: stall, PC redirect, and a multi-cycle flush of IF/ID.

## Interface
- `XLEN`, 32, operand/PC width
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a taken branch (≥1)
- `CNT_W`, 16, width of taken-branch counter
- `clk`  in  1  core clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `br_valid`  in  1  conditional branch present in ID
- `br_funct3`  in  3  branch funct3
- `opnd_ready`  in  1  rs1/rs2 data valid (low while a load result is outstanding)
- `rs1_data`, `rs2_data`  in  XLEN  operands
- `pc`, `imm`  in  XLEN  branch PC and sign-extended B-immediate
- `cnt_clr`  in  1  synchronous clear of `taken_cnt`
- `stall`  out  1  hold PC and IF/ID
- `flush`  out  1  kill IF/ID contents
- `pc_sel`  out  1  select `pc_target` as next PC
- `pc_target`  out  XLEN  registered branch target
- `br_done`  out  1  one-cycle pulse: branch resolved
- `br_taken`  out  1  condition result, valid with `br_done`
- `br_illegal`  out  1  pulse with `br_done`: funct3 010/011
- `br_misalign`  out  1  pulse with `br_done`: taken target[1:0] ≠ 0
- `taken_cnt`  out  CNT_W  redirects performed

## Operation
- States: IDLE, WAIT, EVAL, REDIRECT.
- IDLE, `br_valid` & `opnd_ready`: capture funct3, rs1, rs2, pc, imm → EVAL. IDLE, `br_valid` & !`opnd_ready` → WAIT.
- WAIT: capture on the first cycle `opnd_ready`=1 → EVAL.
- EVAL: evaluate on captured registers.
  - Registered outputs for next cycle: `br_done`=1, `br_taken`=cond, `pc_target`=pc+imm.
  - cond true, target aligned → REDIRECT with `pc_sel`=1.
  - Otherwise → IDLE.
- Conditions:
  - 000 EQ, 001 NE.
  - 100 LT and 101 GE are signed.
  - 110 LTU and 111 GEU are unsigned.
  - 010/011: `br_taken`=0, `br_illegal`=1.
- Target: pc+imm modulo 2^XLEN; carry discarded.
- Misaligned taken target: `br_taken`=1, `br_misalign`=1, `pc_sel`=0, no flush, → IDLE.
- REDIRECT lasts FLUSH_CYCLES cycles, then → IDLE.
  - `flush`=1 for every REDIRECT cycle; `pc_sel`=1 only in the first.
  - `br_valid` is ignored in REDIRECT.
- `taken_cnt` increments once on each EVAL→REDIRECT and wraps at 2^CNT_W.
  - `cnt_clr` beats a simultaneous increment; the counter reads 0 next cycle.
- `stall` (combinational) = (IDLE & `br_valid`) | WAIT | EVAL | REDIRECT.
- Reset, including mid-REDIRECT or mid-WAIT:
  - Returns to IDLE; all registered outputs and `taken_cnt` = 0.
  - `stall`=0 while `br_valid`=0.

## Timing
- Accept in cycle t (operands ready). EVAL at t+1; `br_done`/`br_taken`/`pc_target`/`pc_sel` valid at t+2.
- Not taken: IDLE at t+2; a new branch can be accepted in t+2.
- Taken: `flush` high t+2..t+1+FLUSH_CYCLES; IDLE at t+2+FLUSH_CYCLES.
- Each WAIT cycle adds one cycle of latency.
- `br_done`, `br_illegal` and `br_misalign` are single-cycle pulses and never back-to-back for one branch.

## Structure
- Shared package `riscv_br_pkg`:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - State encoding.
- Sub-module `branch_cond`: combinational (funct3, a, b) → {cond, illegal}; replaces the standalone inequality comparator.
- Target adder and FSM live in `branch_ctrl`.

## Test plan
- BEQ rs1=rs2=0x5, pc=0x100, imm=0x20:
  - `br_done`/`br_taken`/`pc_sel` at t+2, `pc_target`=0x120.
  - `flush` 2 cycles; `taken_cnt`=1.
- BNE with `opnd_ready` low for 3 cycles, rs1=1, rs2=2:
  - `stall` held throughout.
  - Resolves taken at t+5.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with same operands → not taken; `br_done` at t+2, no flush, IDLE at t+2.
- pc=0xFFFFFFFC, imm=8, BGE 0≥0 → `pc_target`=0x4. Same with imm=0x6 → `br_misalign`=1, `pc_sel`=0.
- funct3=010 → `br_illegal` pulse, `br_taken`=0, counter unchanged.
- `rst_n` low during the first REDIRECT cycle → `flush`/`pc_sel`/`taken_cnt` = 0 immediately. `cnt_clr` coincident with a taken EVAL → `taken_cnt`=0.
